// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths, reset polarity and helpers for the inter-stage pipeline register.
package pipe_stage_reg_pkg;

  localparam int unsigned PC_INST_BUS_LEN = 64;
  localparam int unsigned STAGE_BUS_LEN   = 64;
  localparam int unsigned OCC_W           = 2;
  localparam logic        RST_ENABLE      = 1'b1;

  // Number of set valid bits across the main and skid slots.
  function automatic logic [OCC_W-1:0] count_valid(input logic main_v, input logic skid_v);
    return OCC_W'(main_v) + OCC_W'(skid_v);
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline holding slot: a valid bit plus PC/instruction and payload registers.
// Clear wins over load for the valid bit; payload only changes on load.
module pipe_stage_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned PC_INST_W = PC_INST_BUS_LEN,
  parameter int unsigned DATA_W    = STAGE_BUS_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [PC_INST_W-1:0] ld_pc_inst,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 valid,
  output logic [PC_INST_W-1:0] pc_inst,
  output logic [DATA_W-1:0]    data
);

  logic                 valid_d, valid_q;
  logic [PC_INST_W-1:0] pc_inst_d, pc_inst_q;
  logic [DATA_W-1:0]    data_d, data_q;

  always_comb begin
    valid_d   = valid_q;
    pc_inst_d = pc_inst_q;
    data_d    = data_q;
    if (load) begin
      valid_d   = 1'b1;
      pc_inst_d = ld_pc_inst;
      data_d    = ld_data;
    end
    if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      valid_q   <= 1'b0;
      pc_inst_q <= '0;
      data_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_inst_q <= pc_inst_d;
      data_q    <= data_d;
    end
  end

  assign valid   = valid_q;
  assign pc_inst = pc_inst_q;
  assign data    = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/allowin handshake and flush.
// Define PIPE_STAGE_SKID_EN to add a skid slot that registers the upstream allowin.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned PC_INST_W = PC_INST_BUS_LEN,
  parameter int unsigned DATA_W    = STAGE_BUS_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_allowin,
  input  logic [PC_INST_W-1:0] in_pc_inst,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_INST_W-1:0] out_pc_inst,
  output logic [DATA_W-1:0]    out_data,
  output logic [OCC_W-1:0]     occupancy
);

  logic                 main_valid;
  logic                 accept;
  logic                 main_load;
  logic                 main_clear;
  logic [PC_INST_W-1:0] main_ld_pc_inst;
  logic [DATA_W-1:0]    main_ld_data;

`ifdef PIPE_STAGE_SKID_EN
  logic                 skid_valid;
  logic                 stall;
  logic                 skid_load;
  logic                 skid_clear;
  logic [PC_INST_W-1:0] skid_pc_inst;
  logic [DATA_W-1:0]    skid_data;

  // allowin comes straight from the skid valid flop; skid refills main before new input.
  always_comb begin
    stall           = main_valid && !out_ready;
    in_allowin      = !skid_valid;
    accept          = in_valid && in_allowin;
    main_load       = !stall && (skid_valid || accept);
    main_clear      = flush || (!stall && !skid_valid && !accept);
    main_ld_pc_inst = skid_valid ? skid_pc_inst : in_pc_inst;
    main_ld_data    = skid_valid ? skid_data : in_data;
    skid_load       = stall && accept;
    skid_clear      = flush || (!stall && skid_valid);
  end

  pipe_stage_slot #(
    .PC_INST_W (PC_INST_W),
    .DATA_W    (DATA_W)
  ) u_skid_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .ld_pc_inst (in_pc_inst),
    .ld_data    (in_data),
    .valid      (skid_valid),
    .pc_inst    (skid_pc_inst),
    .data       (skid_data)
  );

  assign occupancy = count_valid(main_valid, skid_valid);
`else
  logic drain;

  always_comb begin
    drain           = main_valid && out_ready;
    in_allowin      = !main_valid || out_ready;
    accept          = in_valid && in_allowin;
    main_load       = accept;
    main_clear      = flush || (drain && !accept);
    main_ld_pc_inst = in_pc_inst;
    main_ld_data    = in_data;
  end

  assign occupancy = count_valid(main_valid, 1'b0);
`endif

  pipe_stage_slot #(
    .PC_INST_W (PC_INST_W),
    .DATA_W    (DATA_W)
  ) u_main_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (main_load),
    .clear      (main_clear),
    .ld_pc_inst (main_ld_pc_inst),
    .ld_data    (main_ld_data),
    .valid      (main_valid),
    .pc_inst    (out_pc_inst),
    .data       (out_data)
  );

  assign out_valid = main_valid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: FIFO queue model plus directed literal checks.
// Honours PIPE_STAGE_SKID_EN the same way the design does.
module tb_pipe_stage_reg;

  localparam int unsigned PW = 64;
  localparam int unsigned DW = 64;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_allowin;
  logic [PW-1:0] in_pc_inst = '0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pc_inst;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.PC_INST_W(PW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_allowin  (in_allowin),
    .in_pc_inst  (in_pc_inst),
    .in_data     (in_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc_inst (out_pc_inst),
    .out_data    (out_data),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pc;
    logic [DW-1:0] d;
  } entry_t;

  // Model: an in-order queue of held entries, bounded by the slot count.
  entry_t q[$];
  entry_t head;
  bit     head_known;

  function automatic bit model_allowin();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    entry_t e;
    bit acc;
    if (rst) begin
      q.delete();
      head.pc    = '0;
      head.d     = '0;
      head_known = 1'b1;
    end else begin
      acc  = in_valid && model_allowin();
      e.pc = in_pc_inst;
      e.d  = in_data;
      if (flush) begin
        q.delete();
        head_known = 1'b0;
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(e);
        if (q.size() > 0) begin
          head       = q[0];
          head_known = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("m_occupancy", 64'(occupancy), 64'(q.size()));
      chk("m_in_allowin", 64'(in_allowin), 64'(model_allowin()));
      if (q.size() > 0 || head_known) begin
        chk("m_out_data", out_data, head.d);
        chk("m_out_pc_inst", out_pc_inst, head.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [DW-1:0] d, input logic rdy);
    in_valid   = v;
    in_data    = d;
    in_pc_inst = 64'h1000 + d;
    out_ready  = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    // reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_allowin", 64'(in_allowin), 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_pc", out_pc_inst, 64'd0);

    // back-to-back stream, one cycle latency, no bubbles
    for (int k = 1; k <= 4; k++) begin
      offer(1'b1, 64'(k), 1'b1);
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", out_data, 64'(k));
    end
    offer(1'b0, 64'd0, 1'b1);
    tick();
    chk("stream_end_valid", 64'(out_valid), 64'd0);

    // downstream stall with a second offer
    offer(1'b1, 64'hA, 1'b0);
    tick();
    chk("stall_head_a", out_data, 64'hA);
    offer(1'b1, 64'hB, 1'b0);
    #1;
    chk("stall_allowin_now", 64'(in_allowin), (CAP == 2) ? 64'd1 : 64'd0);
    tick();
    chk("stall_occ", 64'(occupancy), 64'(CAP));
    chk("stall_allowin_next", 64'(in_allowin), 64'd0);
    tick();
    tick();
    offer(1'b0, 64'd0, 1'b1);
    chk("release_first", out_data, 64'hA);
    tick();
    if (CAP == 2) chk("release_second", out_data, 64'hB);
    chk("release_second_valid", 64'(out_valid), (CAP == 2) ? 64'd1 : 64'd0);
    tick();
    chk("release_empty", 64'(out_valid), 64'd0);

    // flush while full and offering
    offer(1'b1, 64'hC1, 1'b0);
    tick();
    offer(1'b1, 64'hC2, 1'b0);
    tick();
    chk("flush_pre_occ", 64'(occupancy), 64'(CAP));
    offer(1'b1, 64'hC3, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 64'd0, 1'b0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    tick();
    chk("flush_dropped", 64'(out_valid), 64'd0);

    // bubble: payload holds after drain
    offer(1'b1, 64'h55, 1'b1);
    tick();
    chk("bubble_head", out_data, 64'h55);
    offer(1'b0, 64'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bubble_valid", 64'(out_valid), 64'd0);
      chk("bubble_hold", out_data, 64'h55);
    end

    // reset in the middle of a transfer
    offer(1'b1, 64'h77, 1'b0);
    tick();
    chk("midrst_pre_valid", 64'(out_valid), 64'd1);
    offer(1'b1, 64'h78, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_occ", 64'(occupancy), 64'd0);
    chk("midrst_data", out_data, 64'd0);
    chk("midrst_allowin", 64'(in_allowin), 64'd1);
    offer(1'b0, 64'd0, 1'b1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("postrst_valid", 64'(out_valid), 64'd0);
    end

    // mixed traffic checked against the model every cycle
    for (int n = 0; n < 300; n++) begin
      offer(($urandom % 4) != 0, 64'({$urandom, $urandom}), ($urandom % 3) != 0);
      flush = (($urandom % 25) == 0);
      tick();
    end
    flush = 1'b0;
    offer(1'b0, 64'd0, 1'b1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
